uart_tx_top: RTL and testbench
==============================

Name: uart_tx_top

Overview:
- Parameterised UART transmitter top level. Accepts a parallel byte with a single-cycle valid strobe.
- Serialises it on one line as start bit, data bits LSB first, an optional parity bit, and a stop bit. Each bit lasts one clock period, so the clock is the bit-rate clock.
- Sits between a local data producer and the serial TX pin, and reports frame-in-progress on `busy`.

Parameters:
- dataWidth, 8: width of `p_data`, i.e. number of data bits per frame.
- counterWidth, 3: width of the data-bit index counter. Must satisfy 2^counterWidth >= dataWidth.
- muxSelWidth, 3: width of the output-mux select that chooses start / data / parity / stop / idle level.

Ports:
- clk, input, 1: bit clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- p_data, input, dataWidth: parallel data to transmit; sampled only when accepted.
- data_valid, input, 1: request strobe; one cycle high is sufficient.
- par_en, input, 1: 1 = insert a parity bit; 0 = no parity bit.
- par_type, input, 1: 0 = even parity, 1 = odd parity.
- tx_out, output, 1: serial line; idle high.
- busy, output, 1: high while a frame is on the line.

Behaviour:
- Reset (asynchronous, while rst=1): state IDLE, tx_out=1, busy=0, bit counter=0, data/config registers cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - On a rising edge with data_valid=1, latch p_data, par_en and par_type into internal registers, and go to START.
- START: tx_out=0, busy=1, for one cycle, then go to DATA.
- DATA:
  - For dataWidth cycles, tx_out = latched_data[idx], with idx from 0 to dataWidth-1 (LSB first).
  - When idx = dataWidth-1, go to PARITY if latched par_en=1, else go to STOP.
- PARITY: one cycle.
  - tx_out = ^latched_data when par_type=0 (even).
  - tx_out = ~^latched_data when par_type=1 (odd).
- STOP: one cycle, tx_out=1, busy=1; then go to IDLE.
- Outputs are registered:
  - tx_out and busy change on the same rising edge.
  - busy rises on the same edge where tx_out first shows the start bit.
  - busy falls on the edge where the line returns to idle after the stop bit.
- Latency: start bit appears on the first rising edge after data_valid is sampled high (1 cycle).
- Frame length: dataWidth+3 cycles with parity (11 for dataWidth=8); dataWidth+2 without parity.
- Line bit order for 8-bit data with parity is 0, d0..d7, p, 1. Expressed as a vector with the first-sent bit at bit 0, this equals {1, parity, data, 0}.
- Ignored inputs:
  - data_valid while not in IDLE is ignored. No queueing, no abort.
  - p_data, par_en and par_type changes mid-frame have no effect.
- Back-to-back frames: a request is accepted only in IDLE. This gives at least one idle-high cycle between frames.
- Reset mid-frame: immediately aborts. tx_out=1, busy=0, the pending frame is discarded.
- Parity is always computed over the latched data, never the live input.

Test Plan:
- 0xA5, par_en=1, par_type=0 (even) -> line bits 0,1,0,1,0,0,1,0,1,0,1. Captured vector = 11'b1_0_10100101_0. busy high for exactly 11 cycles.
- 0x01, par_en=1, par_type=0 -> parity bit 1, vector 11'b1_1_00000001_0. Then 0x01 with par_type=1 -> parity bit 0.
- 0xFF, par_en=0 -> 10-bit frame 0, eight 1s, 1. busy high for exactly 10 cycles, no parity slot.
- Sequence of 10 bytes (0x00, 0xFF, 0x55, 0xAA, 0x3C, 0xC3, 0x80, 0x7E, 0x12, 0xED), each sent after busy falls -> every frame matches {1, ^data, data, 0}.
- Second data_valid pulse with 0x00 during the 3rd data bit of a 0xA5 frame -> current frame unchanged, no second frame produced.
- rst asserted during DATA of a 0x5A frame -> tx_out=1 and busy=0 immediately (asynchronous). The next request after release sends a full, correct frame.

Source files
------------

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, stop bit.
// One bit per clock; tx_out and busy are registered and change together.
module uart_tx_top #(
    parameter int dataWidth    = 8,
    parameter int counterWidth = 3,
    parameter int muxSelWidth  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] p_data,
    input  logic                 data_valid,
    input  logic                 par_en,
    input  logic                 par_type,
    output logic                 tx_out,
    output logic                 busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [muxSelWidth-1:0] SelIdle   = muxSelWidth'(0);
    localparam logic [muxSelWidth-1:0] SelStart  = muxSelWidth'(1);
    localparam logic [muxSelWidth-1:0] SelData   = muxSelWidth'(2);
    localparam logic [muxSelWidth-1:0] SelParity = muxSelWidth'(3);
    localparam logic [muxSelWidth-1:0] SelStop   = muxSelWidth'(4);

    localparam logic [counterWidth-1:0] LastIdx = counterWidth'(dataWidth - 1);

    state_e                  state;
    logic [counterWidth-1:0] idx;
    logic [counterWidth-1:0] idx_next;
    logic [dataWidth-1:0]    data_q;
    logic                    par_en_q;
    logic                    par_type_q;
    logic [muxSelWidth-1:0]  sel;
    logic                    par_bit;
    logic                    tx_d;

    function automatic logic line_mux(input logic [muxSelWidth-1:0] s, input logic data_bit,
                                      input logic parity);
        logic level;
        case (s)
            SelStart:  level = 1'b0;
            SelData:   level = data_bit;
            SelParity: level = parity;
            SelStop:   level = 1'b1;
            default:   level = 1'b1;
        endcase
        return level;
    endfunction

    assign par_bit  = par_type_q ? ~^data_q : ^data_q;
    assign idx_next = (state == StStart) ? '0 : idx + 1'b1;

    // sel names the bit that will be on the line after the coming edge
    always_comb begin
        sel = SelIdle;
        unique case (state)
            StIdle:   sel = data_valid ? SelStart : SelIdle;
            StStart:  sel = SelData;
            StData:   sel = (idx != LastIdx) ? SelData : (par_en_q ? SelParity : SelStop);
            StParity: sel = SelStop;
            StStop:   sel = SelIdle;
            default:  sel = SelIdle;
        endcase
        tx_d = line_mux(sel, data_q[idx_next], par_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            idx        <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            tx_out <= tx_d;
            busy   <= (sel != SelIdle);
            case (state)
                StIdle: begin
                    if (data_valid) begin
                        data_q     <= p_data;
                        par_en_q   <= par_en;
                        par_type_q <= par_type;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    idx   <= '0;
                    state <= StData;
                end
                StData: begin
                    if (idx == LastIdx) begin
                        state <= par_en_q ? StParity : StStop;
                    end else begin
                        idx <= idx_next;
                    end
                end
                StParity: state <= StStop;
                StStop:   state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: captures each frame bit by bit and compares
// against hand-computed line vectors and busy durations.
module tb_uart_tx_top;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_type;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_top #(
        .dataWidth   (8),
        .counterWidth(3),
        .muxSelWidth (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_type  (par_type),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_frame(input logic [7:0] d, input logic pen,
                                              input logic ptype);
        if (pen) return {5'b0, 1'b1, (^d) ^ ptype, d, 1'b0};
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Request a frame and record line bits while busy is high (bounded at 16 bits).
    // inject_at >= 0 pulses a conflicting request while that line bit is showing.
    task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptype,
                             input int inject_at, output logic [15:0] vec, output int n);
        vec = '0;
        n   = 0;
        @(negedge clk);
        p_data     = d;
        par_en     = pen;
        par_type   = ptype;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        while (busy === 1'b1 && n < 16) begin
            vec[n] = tx_out;
            if (n == inject_at) begin
                p_data     = 8'h00;
                par_en     = ~pen;
                par_type   = ~ptype;
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx_idle"}, 32'(tx_out), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    logic [15:0] vec;
    int          n;
    logic [7:0]  seq [10] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h80, 8'h7E, 8'h12, 8'hED};

    initial begin
        rst        = 1'b1;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_type   = 1'b0;
        #1;
        check_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // 0xA5 even parity
        run_frame(8'hA5, 1'b1, 1'b0, -1, vec, n);
        check("a5_vec", 32'(vec), 32'b1_0_10100101_0);
        check("a5_len", 32'(n), 32'd11);
        check_idle("a5_end");

        // 0x01 even then odd parity
        run_frame(8'h01, 1'b1, 1'b0, -1, vec, n);
        check("01_even_vec", 32'(vec), 32'b1_1_00000001_0);
        check("01_even_len", 32'(n), 32'd11);
        run_frame(8'h01, 1'b1, 1'b1, -1, vec, n);
        check("01_odd_vec", 32'(vec), 32'b1_0_00000001_0);
        check("01_odd_len", 32'(n), 32'd11);

        // 0xFF without parity
        run_frame(8'hFF, 1'b0, 1'b0, -1, vec, n);
        check("ff_nopar_vec", 32'(vec), 32'b1_11111111_0);
        check("ff_nopar_len", 32'(n), 32'd10);
        check_idle("ff_end");

        // Back-to-back sequence, even parity
        foreach (seq[i]) begin
            run_frame(seq[i], 1'b1, 1'b0, -1, vec, n);
            check($sformatf("seq%0d_vec", i), 32'(vec), 32'(exp_frame(seq[i], 1'b1, 1'b0)));
            check($sformatf("seq%0d_len", i), 32'(n), 32'd11);
        end

        // Conflicting request during d2 (line bit 3) of an 0xA5 frame is ignored
        run_frame(8'hA5, 1'b1, 1'b0, 3, vec, n);
        check("ignore_vec", 32'(vec), 32'b1_0_10100101_0);
        check("ignore_len", 32'(n), 32'd11);
        repeat (3) begin
            check_idle("ignore_after");
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a 0x5A frame
        p_data     = 8'h5A;
        par_en     = 1'b1;
        par_type   = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("rst_start_bit", 32'(tx_out), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd1);
        check("rst_mid_d2", 32'(tx_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_release");
        run_frame(8'h5A, 1'b1, 1'b0, -1, vec, n);
        check("rst_after_vec", 32'(vec), 32'b1_0_01011010_0);
        check("rst_after_len", 32'(n), 32'd11);
        check_idle("rst_after_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
